alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter XLEN, default 64, operand and result width in bits.
REQ-002 Parameter DEPTH, default 2, result buffer entries; fixed at 2 for this release.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  the request fields are valid.
REQ-006 in_ready  output  1  the block can accept a request this cycle.
REQ-007 op  input  4  ALU control code {op_3,op_2,op_1,op_0}.
REQ-008 a  input  XLEN  operand A (rs1).
REQ-009 b  input  XLEN  operand B (rs2 or immediate).
REQ-010 out_valid  output  1  result buffer head is valid.
REQ-011 out_ready  input  1  the consumer takes the head this cycle.
REQ-012 result  output  XLEN  head result.
REQ-013 zero  output  1  head result equals 0; used for beq.
REQ-014 illegal  output  1  head op code was unsupported.

Function
REQ-015 Op decode: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (a minus b).
REQ-016 Any other op code gives result 0, zero 1 and illegal 1, and is still accepted and buffered.
REQ-017 ADD and SUB wrap modulo 2^XLEN, with no carry or overflow output.
REQ-018 A transfer-in occurs when in_valid and in_ready are both high at a rising edge.
REQ-019 A transfer-out occurs when out_valid and out_ready are both high at a rising edge.
REQ-020 The result, zero and illegal values are computed combinationally from op, a and b, and are written into the buffer tail on transfer-in.
REQ-021 Latency is 1 cycle: a transfer-in at edge N gives out_valid high after edge N, provided the buffer was empty.
REQ-022 There is no combinational path from any input to result, zero, illegal or out_valid.
REQ-023 Buffer state is occupancy count (EMPTY=0, ONE=1, FULL=2) with 1-bit read and write pointers that wrap 1 to 0.
REQ-024 Count transitions: push only gives +1; pop only gives -1; push and pop in the same cycle leaves count unchanged, with both pointers advancing.
REQ-025 in_ready is driven from a register, equals (count != FULL), and does not depend on out_ready in the same cycle.
REQ-026 out_valid equals (count != EMPTY).
REQ-027 result, zero and illegal always present the entry at the read pointer.
REQ-028 Results leave in strict acceptance order.
REQ-029 When FULL, in_ready is low; a pop then makes in_ready high on the following cycle.
REQ-030 in_valid while in_ready is low is ignored; the request holds no state.
REQ-031 out_valid, once high, stays high, and the head stays stable, until a transfer-out.

Reset
REQ-032 While rst is high: count=EMPTY, both pointers=0, out_valid=0, in_ready=0.
REQ-033 While rst is high, result, zero and illegal read 0 (entries cleared).
REQ-034 On the first edge after rst falls, in_ready becomes 1.
REQ-035 Reset asserted mid-operation discards all buffered results immediately, with no transfer completing.

Structure
REQ-036 Package alu_pkg holds the op code constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010 and ALU_SUB=4'b0110, shared with alu_control consumers.
REQ-037 alu_pkg also holds the XLEN default.
REQ-038 One combinational sub-module, alu_core (op, a, b -> result, zero, illegal), is instantiated once.
REQ-039 Buffer and handshake logic live in alu_exec.

Verification
REQ-040 Reset, then op=0010, a=5, b=7, out_ready=1 -> one cycle later out_valid=1, result=12, zero=0, illegal=0.
REQ-041 op=0110, a=9, b=9 -> result=0 and zero=1; then op=0110, a=0, b=1 -> result=all ones, zero=0.
REQ-042 out_ready=0 with three back-to-back requests (AND 0xF0&0x3C, OR 0xF0|0x0F, ADD 1+1) -> in_ready drops after 2 accepts and the third is held; raise out_ready -> outputs 0x30, 0xFF, 2 in order, with no loss or duplication.
REQ-043 FULL with out_ready=1 and in_valid=1 -> pop that cycle, in_ready high the next cycle, count never exceeds 2.
REQ-044 op=0101 -> result=0, zero=1, illegal=1, ordering preserved.
REQ-045 Assert rst while FULL -> out_valid and in_ready go 0 without waiting for a clock edge; after release, the buffer is empty and the next request returns after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, default datapath width and buffer occupancy encoding.
package alu_pkg;

    localparam int unsigned XLEN_DEF = 64;
    localparam int unsigned OP_W     = 4;

    localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } buf_cnt_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: decodes the op code and produces result, zero flag and illegal flag.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: one combinational ALU feeding a two-entry result buffer with
// valid/ready handshakes on both sides; all outputs come from flops.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    logic [XLEN-1:0] core_result;
    logic            core_zero;
    logic            core_illegal;

    alu_core #(
        .XLEN (XLEN)
    ) u_core (
        .op      (op),
        .a       (a),
        .b       (b),
        .result  (core_result),
        .zero    (core_zero),
        .illegal (core_illegal)
    );

    buf_cnt_e        count_q, count_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] res_q [DEPTH];
    logic [XLEN-1:0] res_d [DEPTH];
    logic            zero_q [DEPTH];
    logic            zero_d [DEPTH];
    logic            ill_q [DEPTH];
    logic            ill_d [DEPTH];

    logic push;
    logic pop;

    // Next-state for occupancy, pointers, handshake flags and buffer entries.
    always_comb begin
        push        = in_valid && in_ready_q;
        pop         = out_valid_q && out_ready;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        res_d       = res_q;
        zero_d      = zero_q;
        ill_d       = ill_q;

        if (push) begin
            res_d[wr_ptr_q]  = core_result;
            zero_d[wr_ptr_q] = core_zero;
            ill_d[wr_ptr_q]  = core_illegal;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10: begin
                case (count_q)
                    CNT_EMPTY: count_d = CNT_ONE;
                    default:   count_d = CNT_FULL;
                endcase
            end
            2'b01: begin
                case (count_q)
                    CNT_FULL: count_d = CNT_ONE;
                    default:  count_d = CNT_EMPTY;
                endcase
            end
            default: count_d = count_q;
        endcase

        in_ready_d  = (count_d != CNT_FULL);
        out_valid_d = (count_d != CNT_EMPTY);
    end

    // Reset clears entries too, so the head reads zero while held in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= CNT_EMPTY;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                res_q[i]  <= '0;
                zero_q[i] <= 1'b0;
                ill_q[i]  <= 1'b0;
            end
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            ill_q       <= ill_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = res_q[rd_ptr_q];
    assign zero      = zero_q[rd_ptr_q];
    assign illegal   = ill_q[rd_ptr_q];

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed requests push expected results; a monitor
// compares every transfer-out against the queue head.
module tb_alu_exec;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        zero;
    logic        illegal;

    typedef struct {
        logic [63:0] r;
        logic        z;
        logic        il;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    alu_exec #(
        .XLEN  (64),
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: the transfer-out decision is fixed by the negedge, so compare there.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    chk("sb_result", result, e.r);
                    chk("sb_zero", 64'(zero), 64'(e.z));
                    chk("sb_illegal", 64'(illegal), 64'(e.il));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] r, input logic z, input logic il);
        bit   acc;
        exp_t e;
        acc      = 1'b0;
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (in_ready) begin
                acc  = 1'b1;
                e.r  = r;
                e.z  = z;
                e.il = il;
                sb.push_back(e);
            end
            step();
        end
        in_valid = 1'b0;
        chk("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) step();
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'b0000;
        a         = '0;
        b         = '0;
        repeat (2) step();

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);

        rst = 1'b0;
        #1;
        chk("pre_edge_in_ready", 64'(in_ready), 64'd0);
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // ADD with one-cycle latency
        out_ready = 1'b1;
        send(4'b0010, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0);
        chk("lat_out_valid", 64'(out_valid), 64'd1);
        chk("lat_result", result, 64'd12);
        drain();

        // SUB: equal operands and wrap-around
        send(4'b0110, 64'd9, 64'd9, 64'd0, 1'b1, 1'b0);
        send(4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        drain();

        // Backpressure: two accepts fill the buffer, third request is held
        out_ready = 1'b0;
        send(4'b0000, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0);
        send(4'b0001, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        op       = 4'b0010;
        a        = 64'd1;
        b        = 64'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_head", result, 64'h30);
        end
        out_ready = 1'b1;
        step();
        chk("pop_frees_in_ready", 64'(in_ready), 64'd1);
        send(4'b0010, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0);
        drain();

        // Unsupported op code stays in order
        send(4'b0010, 64'd3, 64'd4, 64'd7, 1'b0, 1'b0);
        send(4'b0101, 64'd3, 64'd4, 64'd0, 1'b1, 1'b1);
        send(4'b0001, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0);
        drain();

        // Asynchronous reset while full
        out_ready = 1'b0;
        send(4'b0010, 64'd100, 64'd1, 64'd101, 1'b0, 1'b0);
        send(4'b0010, 64'd200, 64'd2, 64'd202, 1'b0, 1'b0);
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd0);
        chk("async_result", result, 64'd0);
        sb.delete();
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("rerun_in_ready", 64'(in_ready), 64'd1);
        chk("rerun_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        send(4'b0010, 64'd10, 64'd20, 64'd30, 1'b0, 1'b0);
        chk("rerun_lat_valid", 64'(out_valid), 64'd1);
        chk("rerun_lat_result", result, 64'd30);
        drain();

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
